// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer for the lab 8-bit processor.
// Owns the fetch program counter, drives the instruction memory address,
// captures fetched bytes into an instruction register and offers them to the
// decoder over a valid/ready handshake. Branch requests redirect fetch with a
// one-cycle bubble.
// Optional build macro: FETCH_HALT_DETECT_EN -- when defined, accepting the
// HALT_OPCODE byte in RUN stops fetch and parks the controller in HALT.
module fetch_controller #(
  parameter int                   ADDR_W      = 8,
  parameter int                   INSTR_W     = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = 8'hFF
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_q,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  input  logic               branch_take,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [1:0]         state,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             cur_state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt;

  logic accept;
  logic free;

  assign accept   = instr_valid & instr_ready;
  assign free     = ~instr_valid | accept;
  assign mem_addr = fetch_pc;
  assign state    = cur_state;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (cur_state == S_HALT);
`else
  assign halted = 1'b0;
  // Halt detection is compiled out; the opcode parameter is intentionally idle.
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
`endif

  // State and datapath registers; reset discards any in-flight instruction.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cur_state   <= S_IDLE;
      fetch_pc    <= RESET_PC;
      instr       <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      cur_state   <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      instr       <= instr_nxt;
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // Next-state and next-register values; branch beats halt beats pause beats fetch.
  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt    = cur_state;
    fetch_pc_nxt = fetch_pc;
    instr_nxt    = instr;
    pc_nxt       = pc;
    valid_nxt    = instr_valid;

    case (cur_state)
      S_IDLE: begin
        // No fetch; a pending instruction can still be consumed.
        if (accept) valid_nxt = 1'b0;
        if (branch_take) begin
          fetch_pc_nxt = branch_target;
          valid_nxt    = 1'b0;
        end
        if (run) state_nxt = S_RUN;
      end

      S_RUN: begin
        if (branch_take) begin
          // Flush: the slot is emptied whether or not it was accepted.
          fetch_pc_nxt = branch_target;
          valid_nxt    = 1'b0;
        end
`ifdef FETCH_HALT_DETECT_EN
        else if (accept && (instr == HALT_OPCODE)) begin
          // Halt consumed; suppress the fetch, fetch_pc already points past it.
          state_nxt = S_HALT;
          valid_nxt = 1'b0;
        end
`endif
        else if (!run) begin
          state_nxt = S_IDLE;
          if (accept) valid_nxt = 1'b0;
        end else if (free) begin
          instr_nxt    = mem_q;
          pc_nxt       = fetch_pc;
          valid_nxt    = 1'b1;
          fetch_pc_nxt = fetch_pc + ADDR_W'(1);
        end
      end

      S_HALT: begin
        valid_nxt = 1'b0;
        if (branch_take) fetch_pc_nxt = branch_target;
        if (!run) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of latency, stall, branch, wrap, pause
// and async reset, followed by randomized traffic scored against an
// instruction-stream model (next expected address, redirected by branches).
module tb_fetch_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic       branch_take;
  logic [7:0] branch_target;
  logic [1:0] state;
  logic       halted;

  logic [7:0] mem [256];
  assign mem_q = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  // Scoreboard state for the randomized phase.
  logic [7:0] redirect_q [$];
  logic [7:0] exp_next;
  int         accepted = 0;
  logic       mon_en   = 1'b0;

  fetch_controller dut (
    .Clock         (clk),
    .Resetn        (rst_n),
    .run           (run),
    .mem_addr      (mem_addr),
    .mem_q         (mem_q),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .state         (state),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] a,
                            input logic [7:0] p, input logic [7:0] i);
    check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, ".mem_addr"}, {24'd0, mem_addr}, {24'd0, a});
    if (v) begin
      check({tag, ".pc"}, {24'd0, pc}, {24'd0, p});
      check({tag, ".instr"}, {24'd0, instr}, {24'd0, i});
    end
  endtask

  // Monitor: on each accept, compare the delivered instruction with the model's
  // next expected address; then apply any redirect issued for this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
`ifndef FETCH_HALT_DETECT_EN
      check("halted_low", {31'd0, halted}, 32'd0);
`endif
      if (instr_valid && instr_ready) begin
        check("sb.pc", {24'd0, pc}, {24'd0, exp_next});
        check("sb.instr", {24'd0, instr}, {24'd0, mem[exp_next]});
        exp_next = exp_next + 8'd1;
        accepted++;
      end
      if (branch_take) begin
        if (redirect_q.size() == 0) begin
          check("sb.redirect_queue", 32'd0, 32'd1);
        end else begin
          exp_next = redirect_q.pop_front();
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hE7;
    mem[8'h01] = 8'hE9;
    mem[8'h02] = 8'hC1;
    mem[8'h10] = 8'h5A;
    mem[8'hFE] = 8'h3C;
    mem[8'hFF] = 8'hA5;

    run = 1'b0; instr_ready = 1'b0; branch_take = 1'b0; branch_target = 8'h00;
    rst_n = 1'b0;
    #12;
    check("reset.valid", {31'd0, instr_valid}, 32'd0);
    check("reset.state", {30'd0, state}, 32'd0);
    check("reset.mem_addr", {24'd0, mem_addr}, 32'd0);
    check("reset.instr", {24'd0, instr}, 32'd0);
    check("reset.pc", {24'd0, pc}, 32'd0);
    check("reset.halted", {31'd0, halted}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Sequential fetch.
    tick();
    run = 1'b1; instr_ready = 1'b1;
    tick();
    check("seq.state_run", {30'd0, state}, 32'd1);
    expect_out("seq.enter", 1'b0, 8'h00, 8'h00, 8'h00);
    tick(); expect_out("seq0", 1'b1, 8'h01, 8'h00, 8'hE7);
    tick(); expect_out("seq1", 1'b1, 8'h02, 8'h01, 8'hE9);

    // Stall three cycles on E9.
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); expect_out("stall", 1'b1, 8'h02, 8'h01, 8'hE9);
    end
    instr_ready = 1'b1;
    tick(); expect_out("seq2", 1'b1, 8'h03, 8'h02, 8'hC1);

    // Branch coinciding with an accept: one bubble then the target.
    branch_take = 1'b1; branch_target = 8'h10;
    tick(); expect_out("br.bubble", 1'b0, 8'h10, 8'h00, 8'h00);
    branch_take = 1'b0;
    tick(); expect_out("br.target", 1'b1, 8'h11, 8'h10, 8'h5A);

    // Wrap-around of the fetch counter.
    branch_take = 1'b1; branch_target = 8'hFE;
    tick(); expect_out("wrap.bubble", 1'b0, 8'hFE, 8'h00, 8'h00);
    branch_take = 1'b0;
    tick(); expect_out("wrap.fe", 1'b1, 8'hFF, 8'hFE, 8'h3C);
    tick(); expect_out("wrap.ff", 1'b1, 8'h00, 8'hFF, 8'hA5);
    tick(); expect_out("wrap.00", 1'b1, 8'h01, 8'h00, 8'hE7);

    // Pause: instruction retained, no fetch.
    run = 1'b0; instr_ready = 1'b0;
    tick();
    check("pause.state", {30'd0, state}, 32'd0);
    expect_out("pause.a", 1'b1, 8'h01, 8'h00, 8'hE7);
    tick(); expect_out("pause.b", 1'b1, 8'h01, 8'h00, 8'hE7);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    check("areset.valid", {31'd0, instr_valid}, 32'd0);
    check("areset.state", {30'd0, state}, 32'd0);
    check("areset.mem_addr", {24'd0, mem_addr}, 32'd0);
    check("areset.instr", {24'd0, instr}, 32'd0);
    check("areset.pc", {24'd0, pc}, 32'd0);
    tick();
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic against the stream model.
    exp_next = 8'h00;
    mon_en   = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      run         = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      branch_take = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom);
      if (branch_take) redirect_q.push_back(branch_target);
    end
    tick();
    branch_take = 1'b0; run = 1'b0; instr_ready = 1'b1;
    repeat (3) tick();
    mon_en = 1'b0;
    check("sb.throughput", {31'd0, (accepted >= 300)}, 32'd1);
    check("sb.redirects_drained", redirect_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
